// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard information in, forwarding/stall/flush controls out.
// The master side is the pipeline datapath and the slave side is the hazard controller.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       RA1D, RA2D, RA1E, RA2E;
   logic [3:0]       WA3E, WA3M, WA3W;
   logic             RegWriteM, RegWriteW, MemtoRegE;
   logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic             MemReqM, MemReadyM;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             MemErr;
   logic [CNT_W-1:0] StallCount;

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      output RegWriteM, RegWriteW, MemtoRegE,
      output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
      output MemReqM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, MemErr, StallCount
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      input  RegWriteM, RegWriteW, MemtoRegE,
      input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
      input  MemReqM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, MemErr, StallCount
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a five-stage ARM pipeline: operand forwarding,
// load-use / PC-write stalls, memory-wait freeze with timeout, and a saturating stall counter.
module hazard_ctrl #(
   parameter int WAIT_LIMIT = 8,
   parameter int CNT_W      = 16
) (
   input logic         clk,
   input logic         reset,
   hazard_ctrl_if.slave hz
);
   localparam int WC_W = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

   state_t            state_reg, state_next;
   logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic [CNT_W-1:0]  stall_count_reg;
   logic              ldr_stall, pc_wr_pending, mem_stall, frozen, stall_f;
   logic [3:0]        ra_e [2];
   logic [1:0]        fwd  [2];

   assign ra_e[0] = hz.RA1E;
   assign ra_e[1] = hz.RA2E;

   // Memory stage wins over writeback; R15 reads the PC path, never a forwarded value.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd[gi] = (hz.RegWriteM && ra_e[gi] == hz.WA3M && ra_e[gi] != 4'd15) ? 2'b10 :
                          (hz.RegWriteW && ra_e[gi] == hz.WA3W && ra_e[gi] != 4'd15) ? 2'b01 :
                                                                                      2'b00;
      end
   endgenerate

   assign ldr_stall     = hz.MemtoRegE & ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
   assign pc_wr_pending = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
   assign mem_stall     = hz.MemReqM & ~hz.MemReadyM;
   assign frozen        = mem_stall | (state_reg == S_ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= S_RUN;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         S_RUN: begin
            if (mem_stall) begin
               state_next    = S_WAIT;
               wait_cnt_next = WC_W'(1);
            end
         end
         S_WAIT: begin
            if (hz.MemReadyM || !hz.MemReqM) begin
               state_next    = S_RUN;
               wait_cnt_next = '0;
            end else if (wait_cnt_reg == WC_W'(WAIT_LIMIT)) begin
               state_next = S_ERR;
            end else begin
               wait_cnt_next = wait_cnt_reg + WC_W'(1);
            end
         end
         S_ERR:   state_next = S_ERR;
         default: begin
            state_next    = S_RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // While frozen nothing is killed: a bubble goes into W and every other hazard is ignored.
   always_comb begin
      stall_f      = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushW    = 1'b0;
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (reset) begin
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.ForwardAE = fwd[0];
         hz.ForwardBE = fwd[1];
         if (frozen) begin
            stall_f   = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
         end else begin
            stall_f   = ldr_stall | pc_wr_pending;
            hz.StallD = ldr_stall;
            hz.FlushD = pc_wr_pending | hz.PCSrcW | hz.BranchTakenE;
            hz.FlushE = ldr_stall | hz.BranchTakenE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_reg <= '0;
      end else if (stall_f && stall_count_reg != '1) begin
         stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
   end

   assign hz.StallF     = stall_f;
   assign hz.MemErr     = (state_reg == S_ERR);
   assign hz.StallCount = stall_count_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
   localparam int WL   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CW)) hz ();
   hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz(hz.slave));

   int total  = 0;
   int passed = 0;
   // model: sticky timeout flag, consecutive frozen-by-memory cycles, stall-cycle count
   bit m_err;
   int m_n;
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic clear_inputs();
      {hz.RA1D, hz.RA2D, hz.RA1E, hz.RA2E, hz.WA3E, hz.WA3M, hz.WA3W} = '0;
      {hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE} = '0;
      {hz.PCSrcD, hz.PCSrcE, hz.PCSrcM, hz.PCSrcW, hz.BranchTakenE} = '0;
      {hz.MemReqM, hz.MemReadyM} = '0;
   endtask

   task automatic m_clear();
      m_err = 0;
      m_n   = 0;
      m_cnt = 0;
   endtask

   function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
      if (ra == 4'd15) return 2'b00;
      if (hz.RegWriteM && ra == hz.WA3M) return 2'b10;
      if (hz.RegWriteW && ra == hz.WA3W) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit exp_frozen();
      return m_err || (hz.MemReqM && !hz.MemReadyM);
   endfunction

   function automatic bit exp_ldr();
      return hz.MemtoRegE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
   endfunction

   function automatic bit exp_pcw();
      return hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
   endfunction

   task automatic check_all();
      logic [1:0] ea, eb;
      bit sf, sd, sem, fd, fe, fw;
      if (reset) begin
         ea = 0; eb = 0; sf = 0; sd = 0; sem = 0; fd = 1; fe = 1; fw = 1;
      end else begin
         ea = exp_fwd(hz.RA1E);
         eb = exp_fwd(hz.RA2E);
         if (exp_frozen()) begin
            sf = 1; sd = 1; sem = 1; fd = 0; fe = 0; fw = 1;
         end else begin
            sf  = exp_ldr() || exp_pcw();
            sd  = exp_ldr();
            sem = 0;
            fd  = exp_pcw() || hz.PCSrcW || hz.BranchTakenE;
            fe  = exp_ldr() || hz.BranchTakenE;
            fw  = 0;
         end
      end
      check("ForwardAE", hz.ForwardAE, ea);
      check("ForwardBE", hz.ForwardBE, eb);
      check("StallF", hz.StallF, sf);
      check("StallD", hz.StallD, sd);
      check("StallE", hz.StallE, sem);
      check("StallM", hz.StallM, sem);
      check("FlushD", hz.FlushD, fd);
      check("FlushE", hz.FlushE, fe);
      check("FlushW", hz.FlushW, fw);
      check("MemErr", hz.MemErr, m_err);
      check("StallCount", hz.StallCount, m_cnt);
   endtask

   task automatic model_update();
      bit sf;
      if (reset) begin
         m_clear();
      end else begin
         sf = exp_frozen() || exp_ldr() || exp_pcw();
         if (sf && m_cnt < CMAX) m_cnt++;
         if (!m_err) begin
            if (hz.MemReqM && !hz.MemReadyM) begin
               m_n++;
               if (m_n == WL + 1) m_err = 1;
            end else begin
               m_n = 0;
            end
         end
      end
   endtask

   // inputs are already set; check combinational outputs, then clock and advance the model
   task automatic cycle();
      #2 check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [3:0] rnd_reg();
      int r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 4'd15 : 4'(r);
   endfunction

   int cnt0;

   initial begin
      clear_inputs();
      m_clear();
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check_all();
      reset = 1'b0;
      $display("step reset done");

      hz.RegWriteM = 1; hz.WA3M = 3; hz.RA1E = 3;
      cycle();
      hz.RegWriteW = 1; hz.WA3W = 3;
      cycle();
      hz.RegWriteM = 0;
      cycle();
      hz.RegWriteM = 1; hz.RA1E = 15; hz.WA3M = 15; hz.RA2E = 3;
      cycle();
      clear_inputs();
      $display("step forwarding done");

      hz.MemtoRegE = 1; hz.WA3E = 5; hz.RA2D = 5; hz.RA1D = 1;
      cnt0 = m_cnt;
      cycle();
      check("ldr_count_inc", hz.StallCount, cnt0 + 1);
      clear_inputs();
      cycle();
      $display("step load-use done");

      hz.PCSrcD = 1; cycle();
      hz.PCSrcD = 0; hz.PCSrcE = 1; cycle();
      hz.PCSrcE = 0; hz.PCSrcM = 1; cycle();
      hz.PCSrcM = 0; hz.PCSrcW = 1; cycle();
      clear_inputs(); cycle();
      $display("step branch done");

      hz.MemReqM = 1; cycle();
      hz.MemtoRegE = 1; hz.WA3E = 7; hz.RA1D = 7; cycle();
      cycle();
      hz.MemtoRegE = 0; hz.MemReadyM = 1; cycle();
      clear_inputs(); cycle();
      check("wait3_no_err", hz.MemErr, 0);
      hz.MemReqM = 1; hz.MemReadyM = 1; cycle();
      clear_inputs();
      hz.MemReqM = 1;
      repeat (WL) cycle();
      hz.MemReadyM = 1; cycle();
      clear_inputs(); cycle();
      check("ready_at_limit_no_err", hz.MemErr, 0);
      $display("step memory wait done");

      hz.MemtoRegE = 1; hz.WA3E = 2; hz.RA1D = 2; hz.BranchTakenE = 1;
      cycle();
      clear_inputs();
      $display("step ldr+branch done");

      hz.MemReqM = 1;
      repeat (WL) cycle();
      check("timeout_before", hz.MemErr, 0);
      cycle();
      check("timeout_err", hz.MemErr, 1);
      hz.MemReqM = 0; hz.PCSrcW = 1;
      repeat (3) cycle();
      #2 reset = 1'b1;
      #1 m_clear();
      check("async_rst_memerr", hz.MemErr, 0);
      check("async_rst_count", hz.StallCount, 0);
      cycle();
      reset = 1'b0;
      clear_inputs();
      cycle();
      $display("step timeout and reset done");

      hz.PCSrcD = 1;
      repeat (20) cycle();
      check("saturate", hz.StallCount, CMAX);
      clear_inputs();
      $display("step saturation done");

      for (int i = 0; i < 400; i++) begin
         reset          = 1'b0;
         hz.RA1D        = rnd_reg(); hz.RA2D = rnd_reg();
         hz.RA1E        = rnd_reg(); hz.RA2E = rnd_reg();
         hz.WA3E        = rnd_reg(); hz.WA3M = rnd_reg(); hz.WA3W = rnd_reg();
         hz.RegWriteM   = $urandom_range(0, 1);
         hz.RegWriteW   = $urandom_range(0, 1);
         hz.MemtoRegE   = ($urandom_range(0, 2) == 0);
         hz.PCSrcD      = ($urandom_range(0, 5) == 0);
         hz.PCSrcE      = ($urandom_range(0, 5) == 0);
         hz.PCSrcM      = ($urandom_range(0, 5) == 0);
         hz.PCSrcW      = ($urandom_range(0, 5) == 0);
         hz.BranchTakenE = ($urandom_range(0, 5) == 0);
         hz.MemReqM     = ($urandom_range(0, 1) == 0);
         hz.MemReadyM   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0 || (m_err && $urandom_range(0, 3) == 0)) begin
            reset = 1'b1;
            m_clear();
         end
         cycle();
      end
      reset = 1'b0;
      $display("step random done");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
